// File: rtl/led_status_engine.sv
// LED status generator: maps DFU state (or an override) to off/blink/bounce/error/breathe
// patterns, all timed by clock-enables from one free-running prescaler.

package led_status_pkg;
   typedef enum logic [2:0] {
      MODE_OFF     = 3'd0,
      MODE_BLINK   = 3'd1,
      MODE_BOUNCE  = 3'd2,
      MODE_ERROR   = 3'd3,
      MODE_BREATHE = 3'd4
   } mode_e;
endpackage

// One LED: selects its lit bit for the active mode and registers it with pin polarity.
module led_status_lane
   import led_status_pkg::*;
#(
   parameter int LANE       = 0,
   parameter int ACTIVE_LOW = 1,
   parameter int POS_W      = 1
) (
   input  logic             clk_48mhz,
   input  logic             reset_n,
   input  mode_e            mode_q,
   input  logic             blink_bit,
   input  logic             error_bit,
   input  logic             pwm_on,
   input  logic [POS_W-1:0] pos,
   output logic             led
);
   localparam logic OFF_LVL = 1'(ACTIVE_LOW);
   localparam logic [POS_W-1:0] MY_POS = POS_W'(LANE);

   logic lit;

   always_comb begin
      lit = 1'b0;
      case (mode_q)
         MODE_BLINK:   lit = (LANE == 0) && blink_bit;
         MODE_BOUNCE:  lit = (pos == MY_POS);
         MODE_ERROR:   lit = error_bit;
         MODE_BREATHE: lit = pwm_on;
         default:      lit = 1'b0;
      endcase
   end

   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) led <= OFF_LVL;
      else          led <= lit ^ OFF_LVL;
   end
endmodule

module led_status_engine
   import led_status_pkg::*;
#(
   parameter int NUM_LEDS      = 4,
   parameter int ACTIVE_LOW    = 1,
   parameter int PRESCALE_BITS = 26,
   parameter int BLINK_BIT     = 25,
   parameter int ERROR_BIT     = 22,
   parameter int STEP_BIT      = 22,
   parameter int BREATHE_BIT   = 15,
   parameter int PWM_BITS      = 8
) (
   input  logic                clk_48mhz,
   input  logic                reset_n,
   input  logic [7:0]          dfu_state,
   input  logic                override_en,
   input  logic [2:0]          override_mode,
   output logic [NUM_LEDS-1:0] led,
   output logic [2:0]          mode
);
   localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam logic [POS_W-1:0]         POS_MAX = POS_W'(NUM_LEDS - 1);
   localparam logic [POS_W-1:0]         POS_ONE = POS_W'(1);
   localparam logic [PWM_BITS-1:0]      LVL_MAX = '1;
   localparam logic [PWM_BITS-1:0]      LVL_ONE = PWM_BITS'(1);
   localparam logic [PRESCALE_BITS-1:0] PRE_ONE = PRESCALE_BITS'(1);

   mode_e                    mode_q, mode_d;
   logic                     mode_chg;
   logic [PRESCALE_BITS-1:0] prescaler;
   logic [PWM_BITS-1:0]      pwm_cnt, level;
   logic                     lvl_up;
   logic [POS_W-1:0]         pos;
   logic                     dir;
   logic                     step_tick, breathe_tick, pwm_on;
   logic                     unused_prescaler;

   // Mode decode; out-of-range override encodings collapse to OFF.
   always_comb begin
      mode_d = MODE_OFF;
      if (override_en) begin
         if (override_mode <= 3'd4) mode_d = mode_e'(override_mode);
      end else begin
         case (dfu_state)
            8'h00, 8'h01: mode_d = MODE_OFF;
            8'h02:        mode_d = MODE_BLINK;
            8'h09:        mode_d = MODE_BREATHE;
            8'h0A:        mode_d = MODE_ERROR;
            default:      mode_d = MODE_BOUNCE;
         endcase
      end
   end

   assign mode_chg = (mode_d != mode_q);

   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) mode_q <= MODE_OFF;
      else          mode_q <= mode_d;
   end

   assign mode = mode_q;

   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         prescaler <= '0;
         pwm_cnt   <= '0;
      end else begin
         prescaler <= prescaler + PRE_ONE;
         pwm_cnt   <= pwm_cnt + LVL_ONE;
      end
   end

   assign step_tick        = &prescaler[STEP_BIT-1:0];
   assign breathe_tick     = &prescaler[BREATHE_BIT-1:0];
   assign unused_prescaler = ^prescaler;

   // Bounce: endpoints reverse in one step so each end LED gets a single period.
   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         pos <= '0;
         dir <= 1'b1;
      end else if (mode_chg) begin
         pos <= '0;
         dir <= 1'b1;
      end else if (step_tick && (NUM_LEDS > 1)) begin
         if (dir) begin
            if (pos == POS_MAX) begin
               dir <= 1'b0;
               pos <= pos - POS_ONE;
            end else begin
               pos <= pos + POS_ONE;
            end
         end else begin
            if (pos == '0) begin
               dir <= 1'b1;
               pos <= POS_ONE;
            end else begin
               pos <= pos - POS_ONE;
            end
         end
      end
   end

   // Breathe level: triangle 0..max..0 without repeating either endpoint.
   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         level  <= '0;
         lvl_up <= 1'b1;
      end else if (mode_chg) begin
         level  <= '0;
         lvl_up <= 1'b1;
      end else if (breathe_tick) begin
         if (lvl_up) begin
            if (level == LVL_MAX) begin
               lvl_up <= 1'b0;
               level  <= level - LVL_ONE;
            end else begin
               level  <= level + LVL_ONE;
            end
         end else begin
            if (level == '0) begin
               lvl_up <= 1'b1;
               level  <= LVL_ONE;
            end else begin
               level  <= level - LVL_ONE;
            end
         end
      end
   end

   assign pwm_on = (pwm_cnt < level);

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_lane
      led_status_lane #(
         .LANE       (i),
         .ACTIVE_LOW (ACTIVE_LOW),
         .POS_W      (POS_W)
      ) u_lane (
         .clk_48mhz (clk_48mhz),
         .reset_n   (reset_n),
         .mode_q    (mode_q),
         .blink_bit (prescaler[BLINK_BIT]),
         .error_bit (prescaler[ERROR_BIT]),
         .pwm_on    (pwm_on),
         .pos       (pos),
         .led       (led[i])
      );
   end
endmodule

// File: tb/tb_led_status_engine.sv
// Scoreboard bench: a time-based reference model predicts led/mode per clock; a monitor compares.
module tb_led_status_engine;
   localparam int N   = 4;
   localparam int SB  = 2;   // STEP_BIT
   localparam int BB  = 3;   // BLINK_BIT
   localparam int EB  = 1;   // ERROR_BIT
   localparam int BRB = 1;   // BREATHE_BIT
   localparam int PB  = 2;   // PWM_BITS
   localparam int PSB = 8;   // PRESCALE_BITS

   logic         clk_48mhz = 1'b0;
   logic         reset_n   = 1'b0;
   logic [7:0]   dfu_state = 8'h00;
   logic         override_en = 1'b0;
   logic [2:0]   override_mode = 3'd0;
   logic [N-1:0] led;
   logic [2:0]   mode;

   led_status_engine #(
      .NUM_LEDS(N), .ACTIVE_LOW(1), .PRESCALE_BITS(PSB), .BLINK_BIT(BB),
      .ERROR_BIT(EB), .STEP_BIT(SB), .BREATHE_BIT(BRB), .PWM_BITS(PB)
   ) dut (
      .clk_48mhz(clk_48mhz), .reset_n(reset_n), .dfu_state(dfu_state),
      .override_en(override_en), .override_mode(override_mode),
      .led(led), .mode(mode)
   );

   always #5 clk_48mhz = ~clk_48mhz;

   typedef struct {
      logic [N-1:0] led;
      logic [2:0]   mode;
   } exp_t;
   exp_t q[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model state: time since reset and tick counts since the last mode entry.
   int p = 0, pw = 0, m = 0, steps = 0, bt = 0;

   function automatic int tri_pos(int k, int mx);
      int r;
      if (mx == 0) return 0;
      r = k % (2 * mx);
      return (r <= mx) ? r : 2 * mx - r;
   endfunction

   function automatic int dec(logic oe, logic [2:0] om, logic [7:0] ds);
      if (oe) return (om > 3'd4) ? 0 : int'(om);
      case (ds)
         8'h00, 8'h01: return 0;
         8'h02:        return 1;
         8'h09:        return 4;
         8'h0A:        return 3;
         default:      return 2;
      endcase
   endfunction

   function automatic logic [N-1:0] lit_f();
      case (m)
         1: return N'((p >> BB) & 1);
         2: return N'(1 << tri_pos(steps, N - 1));
         3: return (((p >> EB) & 1) != 0) ? '1 : '0;
         4: return (pw < tri_pos(bt, (1 << PB) - 1)) ? '1 : '0;
         default: return '0;
      endcase
   endfunction

   // Reference model: predicts the outputs that appear after each rising edge.
   initial begin
      exp_t e;
      int   nm;
      forever begin
         @(posedge clk_48mhz);
         cyc++;
         if (!reset_n) begin
            p = 0; pw = 0; m = 0; steps = 0; bt = 0;
            q.delete();
         end else begin
            nm     = dec(override_en, override_mode, dfu_state);
            e.led  = lit_f() ^ {N{1'b1}};
            e.mode = 3'(nm);
            q.push_back(e);
            if (nm != m) begin
               steps = 0;
               bt    = 0;
            end else begin
               if ((p % (1 << SB)) == (1 << SB) - 1) steps++;
               if ((p % (1 << BRB)) == (1 << BRB) - 1) bt++;
            end
            p  = (p + 1) % (1 << PSB);
            pw = (pw + 1) % (1 << PB);
            m  = nm;
         end
      end
   end

   // Monitor: compares on the falling edge, away from the DUT update.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_48mhz);
         if (reset_n && q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (led !== e.led) begin
               errors++;
               $display("FAIL led cyc=%0d got=%b exp=%b", cyc, led, e.led);
            end
            checks++;
            if (mode !== e.mode) begin
               errors++;
               $display("FAIL mode cyc=%0d got=%0d exp=%0d", cyc, mode, e.mode);
            end
         end
      end
   end

   task automatic set_in(logic [7:0] ds, logic oe, logic [2:0] om);
      @(negedge clk_48mhz);
      #2;
      dfu_state     = ds;
      override_en   = oe;
      override_mode = om;
   endtask

   task automatic wait_cyc(int n);
      repeat (n) @(posedge clk_48mhz);
   endtask

   task automatic async_reset(logic [7:0] ds_after);
      @(negedge clk_48mhz);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (led !== {N{1'b1}}) begin
         errors++;
         $display("FAIL async_reset_led got=%b exp=%b", led, {N{1'b1}});
      end
      checks++;
      if (mode !== 3'd0) begin
         errors++;
         $display("FAIL async_reset_mode got=%0d exp=0", mode);
      end
      wait_cyc(2);
      @(negedge clk_48mhz);
      #2;
      dfu_state   = ds_after;
      override_en = 1'b0;
      reset_n     = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int hold;
      logic [7:0] ds;
      wait_cyc(3);
      @(negedge clk_48mhz);
      checks++;
      if (led !== {N{1'b1}}) begin
         errors++;
         $display("FAIL reset_led got=%b exp=%b", led, {N{1'b1}});
      end
      checks++;
      if (mode !== 3'd0) begin
         errors++;
         $display("FAIL reset_mode got=%0d exp=0", mode);
      end
      #2;
      reset_n = 1'b1;
      wait_cyc(10);                       // OFF after release

      set_in(8'h02, 1'b0, 3'd0);  wait_cyc(40);   // blink
      set_in(8'h05, 1'b0, 3'd0);  wait_cyc(40);   // bounce
      set_in(8'h0A, 1'b0, 3'd0);  wait_cyc(20);   // error
      set_in(8'h09, 1'b0, 3'd0);  wait_cyc(40);   // breathe

      // Override mid-sweep at pos 2, then return to bounce.
      set_in(8'h05, 1'b0, 3'd0);
      for (int i = 0; i < 60 && !(m == 2 && tri_pos(steps, N - 1) == 2); i++)
         @(posedge clk_48mhz);
      set_in(8'h05, 1'b1, 3'd3);  wait_cyc(10);
      set_in(8'h05, 1'b1, 3'd2);  wait_cyc(30);
      set_in(8'h05, 1'b0, 3'd0);  wait_cyc(10);   // same mode, no restart

      // Reset asserted mid-bounce.
      async_reset(8'h00);
      wait_cyc(8);

      for (int s = 0; s < 50; s++) begin
         case ($urandom_range(0, 6))
            0: ds = 8'h00;
            1: ds = 8'h01;
            2: ds = 8'h02;
            3: ds = 8'h09;
            4: ds = 8'h0A;
            5: ds = 8'h05;
            default: ds = 8'($urandom);
         endcase
         set_in(ds, ($urandom_range(0, 3) == 0), 3'($urandom));
         hold = $urandom_range(1, 40);
         wait_cyc(hold);
         if (s == 25) async_reset(8'h0A);
      end

      set_in(8'h00, 1'b0, 3'd0);
      wait_cyc(4);
      @(negedge clk_48mhz);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
